// File: rtl/subtractor_4bits_pipeline_hs_if.sv
// ----------------------------------------------------------------------------
// subtractor_4bits_pipeline_hs_if
// Purpose : bundles the operand stream (in_valid/in_ready/a/b) and the result
//           stream (out_valid/out_ready/diff/borrow) of the 4-bit pipelined
//           subtractor.
// Modports:
//   master - producer/consumer side (drives operands and out_ready)
//   slave  - subtractor side (drives in_ready and results)
// ----------------------------------------------------------------------------
interface subtractor_4bits_pipeline_hs_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] diff;
  logic       borrow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );
endinterface

// File: rtl/subtractor_4bits_pipeline_hs.sv
// ----------------------------------------------------------------------------
// subtractor_4bits_pipeline_hs
// Purpose : 4-bit unsigned subtractor, {borrow, diff} = {1'b0,a} - {1'b0,b},
//           with valid/ready handshakes on operands and results. The pipeline
//           depth is picked at elaboration: two stages when
//           CLOCK_FREQUENCY > HIGH_SPEED (2-bit borrow chain per stage),
//           otherwise a single stage.
// Ports   :
//   CLK  - clock, rising edge
//   RST  - asynchronous active-low reset, clears all valid and data registers
//   bus  - slave modport: in_valid/in_ready/a/b in, out_valid/out_ready/
//          diff/borrow out (diff, borrow, out_valid are registered)
// Macro   : SUBTRACTOR_SATURATE_EN - when defined, diff is forced to 0 in the
//           last stage whenever the borrow is 1 (borrow still reads 1).
// ----------------------------------------------------------------------------
module subtractor_4bits_pipeline_hs #(
  parameter logic [8:0] CLOCK_FREQUENCY = 9'd100,
  parameter logic [8:0] HIGH_SPEED      = 9'd150
) (
  input  logic                          CLK,
  input  logic                          RST,
  subtractor_4bits_pipeline_hs_if.slave bus
);

  generate
    if (CLOCK_FREQUENCY > HIGH_SPEED) begin : g_high
      // S1: low half of the difference plus the operands' high halves
      logic [2:0] lo;
      logic       s1_valid;
      logic [1:0] s1_dlo;
      logic       s1_c;
      logic [1:0] s1_ahi;
      logic [1:0] s1_bhi;
      // S2: full result
      logic [2:0] hi;
      logic [3:0] s2_diff_next;
      logic       s2_valid;
      logic [3:0] s2_diff;
      logic       s2_borrow;
      logic       s1_advance;
      logic       in_ready;

      assign lo = {1'b0, bus.a[1:0]} - {1'b0, bus.b[1:0]};
      // The borrow out of bit 1 is folded in here, so each stage only
      // carries a 2-bit borrow chain.
      assign hi = {1'b0, s1_ahi} - {1'b0, s1_bhi} - {2'b00, s1_c};

`ifdef SUBTRACTOR_SATURATE_EN
      assign s2_diff_next = hi[2] ? 4'h0 : {hi[1:0], s1_dlo};
`else
      assign s2_diff_next = {hi[1:0], s1_dlo};
`endif

      // S1 can move on when S2 is empty or S2 drains this cycle.
      assign s1_advance = ~s2_valid | bus.out_ready;
      assign in_ready   = ~s1_valid | s1_advance;

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          s1_valid  <= 1'b0;
          s1_dlo    <= 2'b00;
          s1_c      <= 1'b0;
          s1_ahi    <= 2'b00;
          s1_bhi    <= 2'b00;
          s2_valid  <= 1'b0;
          s2_diff   <= 4'h0;
          s2_borrow <= 1'b0;
        end else begin
          if (s1_advance) begin
            s2_valid <= s1_valid;
          end
          if (s1_advance && s1_valid) begin
            s2_diff   <= s2_diff_next;
            s2_borrow <= hi[2];
          end
          if (in_ready) begin
            s1_valid <= bus.in_valid;
          end
          if (in_ready && bus.in_valid) begin
            s1_dlo <= lo[1:0];
            s1_c   <= lo[2];
            s1_ahi <= bus.a[3:2];
            s1_bhi <= bus.b[3:2];
          end
        end
      end

      assign bus.in_ready  = in_ready;
      assign bus.out_valid = s2_valid;
      assign bus.diff      = s2_diff;
      assign bus.borrow    = s2_borrow;
    end else begin : g_low
      logic [4:0] full;
      logic [3:0] s1_diff_next;
      logic       s1_valid;
      logic [3:0] s1_diff;
      logic       s1_borrow;
      logic       in_ready;

      assign full = {1'b0, bus.a} - {1'b0, bus.b};

`ifdef SUBTRACTOR_SATURATE_EN
      assign s1_diff_next = full[4] ? 4'h0 : full[3:0];
`else
      assign s1_diff_next = full[3:0];
`endif

      // Single stage: it advances exactly when the consumer takes the result.
      assign in_ready = ~s1_valid | bus.out_ready;

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          s1_valid  <= 1'b0;
          s1_diff   <= 4'h0;
          s1_borrow <= 1'b0;
        end else begin
          if (in_ready) begin
            s1_valid <= bus.in_valid;
          end
          if (in_ready && bus.in_valid) begin
            s1_diff   <= s1_diff_next;
            s1_borrow <= full[4];
          end
        end
      end

      assign bus.in_ready  = in_ready;
      assign bus.out_valid = s1_valid;
      assign bus.diff      = s1_diff;
      assign bus.borrow    = s1_borrow;
    end
  endgenerate

endmodule
